// File: rtl/div32_iter.sv
// Iterative 32-bit integer divider (restoring radix-2, one quotient bit per cycle).
// Results follow RISC-V DIV/DIVU/REM/REMU, including divide-by-zero and signed overflow.
module div32_iter (
    input  logic        clk,
    input  logic        rst,
    input  logic        hci_rdy_i,
    input  logic        in_en_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        div_signed_i,
    output logic        out_en_o,
    output logic        idle_o,
    output logic [31:0] q_o,
    output logic [31:0] rem_o
);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [32:0] prem_q;
    logic [31:0] quo_q;
    logic [31:0] dvs_q;
    logic        neg_q_q, neg_r_q;
    logic [31:0] q_q, rem_q;
    logic        out_en_q;

    // Operand conditioning at accept time
    logic        sa, sb, div0, ovf;
    logic [31:0] mag_a, mag_b;

    always_comb begin
        sa    = div_signed_i & a_i[31];
        sb    = div_signed_i & b_i[31];
        mag_a = sa ? (~a_i + 32'd1) : a_i;
        mag_b = sb ? (~b_i + 32'd1) : b_i;
        div0  = (b_i == 32'd0);
        ovf   = div_signed_i && (a_i == 32'h8000_0000) && (b_i == 32'hFFFF_FFFF);
    end

    // One restoring step: shift in the next dividend bit, try subtracting the divisor
    logic [32:0] shifted;
    logic [33:0] diff;

    always_comb begin
        shifted = {prem_q[31:0], quo_q[31]};
        diff    = {1'b0, shifted} - {2'b00, dvs_q};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            prem_q   <= 33'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            q_q      <= 32'd0;
            rem_q    <= 32'd0;
            out_en_q <= 1'b0;
        end else if (hci_rdy_i) begin
            out_en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_en_i) begin
                        cnt_q <= 5'd0;
                        dvs_q <= mag_b;
                        if (div0 || ovf) begin
                            // Special results are preloaded raw and bypass CALC
                            quo_q   <= div0 ? 32'hFFFF_FFFF : 32'h8000_0000;
                            prem_q  <= div0 ? {1'b0, a_i} : 33'd0;
                            neg_q_q <= 1'b0;
                            neg_r_q <= 1'b0;
                            state_q <= FIX;
                        end else begin
                            quo_q   <= mag_a;
                            prem_q  <= 33'd0;
                            neg_q_q <= sa ^ sb;
                            neg_r_q <= sa;
                            state_q <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (diff[33]) begin
                        prem_q <= shifted;
                        quo_q  <= {quo_q[30:0], 1'b0};
                    end else begin
                        prem_q <= diff[32:0];
                        quo_q  <= {quo_q[30:0], 1'b1};
                    end
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) state_q <= FIX;
                end
                FIX: begin
                    q_q      <= neg_q_q ? (~quo_q + 32'd1) : quo_q;
                    rem_q    <= neg_r_q ? (~prem_q[31:0] + 32'd1) : prem_q[31:0];
                    out_en_q <= 1'b1;
                    cnt_q    <= 5'd0;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign idle_o   = (state_q == IDLE);
    assign out_en_o = out_en_q;
    assign q_o      = q_q;
    assign rem_o    = rem_q;

endmodule

// File: doc/div32_iter.md
DIV32_ITER -- requirements
Module: div32_iter

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst  input  1  reset, synchronous, active-low; clock clk.
REQ-003 hci_rdy  input  1  global run enable; 0 freezes all internal state and outputs.
REQ-004 in_en  input  1  operation request; sampled only while idle=1.
REQ-005 a  input  32  dividend.
REQ-006 b  input  32  divisor.
REQ-007 div_signed  input  1  1 = signed two's-complement operation, 0 = unsigned.
REQ-008 out_en  output  1  one-cycle result-valid pulse.
REQ-009 idle  output  1  1 = unit can accept a request this cycle.
REQ-010 q  output  32  quotient, registered.
REQ-011 rem  output  32  remainder, registered.

Function
REQ-012 States SHALL be IDLE, CALC and FIX; idle SHALL equal (state==IDLE).
REQ-013 Request acceptance: at an edge with rst=1, hci_rdy=1, state IDLE and in_en=1, the unit SHALL latch a, b and div_signed and leave IDLE.
REQ-014 in_en while idle=0 SHALL be ignored; no queuing.
REQ-015 Signed mode SHALL operate on magnitudes; quotient is negated when the operand signs differ; remainder takes the dividend's sign.
REQ-016 Normal path: the accept edge N SHALL enter CALC with the iteration counter at 0.
REQ-017 Normal path: edges N+1..N+32 SHALL each perform one restoring radix-2 step, MSB first, on a 33-bit partial remainder.
REQ-018 Normal path: edge N+33 SHALL pass through FIX, apply sign correction, and register q and rem.
REQ-019 Normal path: out_en SHALL be 1 and state IDLE for exactly the cycle after edge N+33, giving 33-cycle latency.
REQ-020 Divide-by-zero (b==0, either mode) SHALL skip CALC: edge N+1 registers q=32'hFFFFFFFF and rem=a, and out_en=1 in the following cycle.
REQ-021 Signed overflow (div_signed=1, a=32'h80000000, b=32'hFFFFFFFF) SHALL skip CALC: edge N+1 registers q=32'h80000000 and rem=0, and out_en=1 in the following cycle.
REQ-022 out_en SHALL deassert at the next active edge after its pulse.
REQ-023 A new request accepted in the out_en cycle SHALL be legal, giving back-to-back operation with no bubble.
REQ-024 q and rem SHALL hold their last result until the next result is registered.
REQ-025 hci_rdy=0 SHALL hold state, counter, partial remainder, q, rem, out_en and idle unchanged, and in_en is not sampled.
REQ-026 Under REQ-025, a pending out_en SHALL stay asserted until the first edge with hci_rdy=1.
REQ-027 Arithmetic SHALL be exact for all 2^64 operand pairs in both modes, matching RISC-V DIV/DIVU/REM/REMU.

Reset
REQ-028 At an edge with rst=0 the unit SHALL enter IDLE, with idle=1, out_en=0, q=0, rem=0 and the counter at 0.
REQ-029 rst SHALL take priority over hci_rdy.
REQ-030 rst=0 mid-CALC SHALL abort the operation with no out_en pulse; the next cycle accepts a new request.

Verification
REQ-031 Unsigned: a=100, b=7, div_signed=0 -> out_en exactly 33 cycles after the accept edge, with q=14, rem=2.
REQ-032 Signed: a=-7 (32'hFFFFFFF9), b=2 -> q=32'hFFFFFFFD, rem=32'hFFFFFFFF; unsigned a=32'hFFFFFFFF, b=16 -> q=32'h0FFFFFFF, rem=15.
REQ-033 Special cases: b=0, a=123 (either mode) -> q=32'hFFFFFFFF, rem=123 at 1-cycle latency; a=32'h80000000, b=-1, signed -> q=32'h80000000, rem=0 at 1-cycle latency.
REQ-034 Back-to-back: second request (a=9, b=3) issued in the first result's out_en cycle -> second out_en after 33 more cycles with q=3, rem=0; idle=0 throughout.
REQ-035 Stall: hci_rdy=0 for 5 cycles mid-CALC -> latency becomes 38 cycles and the result is unchanged; hci_rdy=0 during the out_en cycle -> out_en held high.
REQ-036 Reset: rst=0 at cycle 10 of CALC -> no out_en, with idle=1, q=0, rem=0 the next cycle; a random-operand run of 10^5 cases against a reference model shows zero mismatches.
